crack_multi: RTL and testbench
==============================

// Module: crack_multi
// PURPOSE
//  Parametrised multi-lane successor to the single-engine ARC4 key cracker.
//  It partitions a requested key range [key_lo..key_hi] across LANES external
//  decrypt/check lanes, one candidate key per lane.
//  Mode 0 reports the lowest matching key in the range; mode 1 counts every
//  match exhaustively.
//  Sits between the top-level control (en/rdy) and LANES arc4+checker engines
//  sharing the ciphertext memory.
// PARAMETERS
//  LANES  4   number of cracking lanes (1..16)
//  KEY_W  24  key width in bits
//  CNT_W  16  match counter width (saturating)
// PORTS
//  clk        in   1            clock, all state on rising edge
//  rst        in   1            asynchronous active-high reset
//  en         in   1            start request; accepted only when rdy=1
//  rdy        out  1            1 = idle, results stable; 0 = search in progress
//  key_lo     in   KEY_W        first candidate key, sampled on accept
//  key_hi     in   KEY_W        last candidate key (inclusive), sampled on accept
//  mode       in   1            0 = stop on first match, 1 = exhaustive count; sampled on accept
//  key        out  KEY_W        lowest matching key found
//  key_valid  out  1            1 = at least one match found
//  match_cnt  out  CNT_W        matches found (mode 1); 0 or 1 in mode 0
//  lane_en    out  LANES        per-lane one-cycle start pulse
//  lane_key   out  LANES*KEY_W  per-lane candidate key; slice i at [i*KEY_W +: KEY_W]
//  lane_rdy   in   LANES        lane i idle and able to accept
//  lane_done  in   LANES        lane i result pulse (one cycle)
//  lane_match in   LANES        qualified by lane_done: candidate decrypted to valid text
// BEHAVIOUR
//  Reset values: rdy=1, key=0, key_valid=0, match_cnt=0, lane_en=0, lane_key=0, FSM=IDLE.
//  Reset mid-search aborts immediately; lane_en is low from reset assertion.
//  FSM states: IDLE -> DISPATCH -> DRAIN -> IDLE.
//  IDLE:
//   - en=1 accepts the request: latch key_lo/key_hi/mode; clear key, key_valid, match_cnt; rdy->0.
//   - If key_hi<key_lo, go straight to DRAIN with nothing in flight.
//   - en is ignored in all states other than IDLE.
//  DISPATCH:
//   - At most one issue per cycle.
//   - Issue target: the first lane, in round-robin order starting after the last issued lane,
//     with lane_rdy=1 and no outstanding key.
//   - On issue: lane_en[i]=1 for exactly one cycle, lane_key slice i = next key (held until the
//     next issue to that lane), next key +1.
//   - First lane_en occurs the cycle after accept.
//   - Next-key counter is KEY_W+1 bits, so key_hi = all-ones terminates without wrapping to 0.
//   - Go to DRAIN when next key > key_hi, or in mode 0 on the first match.
//  DRAIN:
//   - No new issues. Wait until the per-lane outstanding bits are all 0.
//   - Go to IDLE the cycle after the last outstanding lane_done; rdy=1 in that IDLE cycle.
//  Outstanding bit[i]: set on issue, cleared on lane_done[i]. lane_done[i] with bit[i]=0 is ignored.
//  Result capture (any state except IDLE) for lane_done[i] & lane_match[i]:
//   - If key_valid=0 or lane key < key, then key <= lane key and key_valid <= 1.
//   - Several lanes done in the same cycle: take the smallest matching key.
//   - match_cnt += number of simultaneous matches; saturates at 2^CNT_W-1.
//   - Mode 0: match_cnt ends at 1.
//  Mode 0 guarantee: all lower keys were issued earlier and are drained, so key is the global
//   minimum match in the range.
//  key/key_valid/match_cnt are stable while rdy=1 and held until the next accept.
//  Issue and done for the same lane in the same cycle cannot occur: the lane drops rdy until done.
//  Range of exactly one key (key_lo==key_hi): one issue, then DRAIN.
// TESTING
//  1. LANES=4, range 0x10..0x1F, mode 0, lane model latency 7, match only at 0x17
//     -> key=0x17, key_valid=1, match_cnt=1; no lane_en after the match is seen; rdy returns.
//  2. Same setup, matches at 0x15 and 0x12, lane 0x15 finishes first
//     -> key=0x12 after drain, match_cnt=1 (mode 0).
//  3. mode 1, range 0x000000..0x0000FF, match on every key with bit0=1
//     -> match_cnt=128, key=0x000001, exactly 256 lane_en pulses total.
//  4. key_lo=0x20, key_hi=0x1F -> zero lane_en pulses, rdy=1 within 3 cycles, key_valid=0, match_cnt=0.
//  5. key_lo=key_hi=0xFFFFFF, match
//     -> exactly one issue, key=0xFFFFFF, no wrap to 0x000000 issued.
//  6. rst pulsed mid-DISPATCH with 2 lanes outstanding
//     -> outputs return to reset values asynchronously; stray lane_done afterwards ignored;
//     a new en then completes normally.

Source files
------------

// File: rtl/crack_multi.sv
// rtl/crack_multi.sv - multi-lane ARC4 key-range cracker dispatcher
//
// Splits the key range [key_lo..key_hi] across LANES external decrypt/check
// lanes, one candidate key per lane at a time.
//   mode 0: stop issuing on the first match, drain, report the lowest match.
//   mode 1: issue every key and count every match (saturating).
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   en / rdy            start request (accepted only while rdy=1) / idle flag
//   key_lo, key_hi      inclusive search range, sampled on accept
//   mode                0 = stop on first match, 1 = exhaustive count
//   key, key_valid      lowest matching key found / at least one match
//   match_cnt           number of matches (0 or 1 in mode 0)
//   lane_en             per-lane one-cycle start pulse
//   lane_key            per-lane candidate key, slice i at [i*KEY_W +: KEY_W]
//   lane_rdy            lane i idle and able to accept
//   lane_done           lane i result pulse
//   lane_match          lane i result, qualified by lane_done
module crack_multi #(
  parameter int LANES = 4,
  parameter int KEY_W = 24,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  output logic                   rdy,
  input  logic [KEY_W-1:0]       key_lo,
  input  logic [KEY_W-1:0]       key_hi,
  input  logic                   mode,
  output logic [KEY_W-1:0]       key,
  output logic                   key_valid,
  output logic [CNT_W-1:0]       match_cnt,
  output logic [LANES-1:0]       lane_en,
  output logic [LANES*KEY_W-1:0] lane_key,
  input  logic [LANES-1:0]       lane_rdy,
  input  logic [LANES-1:0]       lane_done,
  input  logic [LANES-1:0]       lane_match
);

  localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_DISPATCH, S_DRAIN} state_t;

  state_t                   state_q, state_d;
  logic [KEY_W:0]           next_q, next_d;     // one extra bit so key_hi = all-ones ends cleanly
  logic [KEY_W-1:0]         hi_q, hi_d;
  logic                     mode_q, mode_d;
  logic [IW-1:0]            last_q, last_d;
  logic [LANES-1:0]         outst_q, outst_d;
  logic [LANES*KEY_W-1:0]   lkey_q, lkey_d;
  logic [KEY_W-1:0]         key_q, key_d;
  logic                     kv_q, kv_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;

  logic [LANES-1:0]         hit;
  logic                     any_hit;
  logic [KEY_W-1:0]         min_key;
  int                       n_hit;
  logic                     can_issue;
  logic                     sel_found;
  logic [IW-1:0]            sel;
  logic [LANES-1:0]         en_c;
  logic [CNT_W:0]           sum;

  always_comb begin
    state_d   = state_q;
    next_d    = next_q;
    hi_d      = hi_q;
    mode_d    = mode_q;
    last_d    = last_q;
    lkey_d    = lkey_q;
    key_d     = key_q;
    kv_d      = kv_q;
    cnt_d     = cnt_q;
    any_hit   = 1'b0;
    min_key   = '0;
    n_hit     = 0;
    sel_found = 1'b0;
    sel       = '0;
    en_c      = '0;
    sum       = '0;

    // Only results from lanes we actually issued to count; stray done pulses
    // (e.g. from work aborted by reset) are dropped here.
    hit = (state_q != S_IDLE) ? (lane_done & lane_match & outst_q) : '0;

    for (int i = 0; i < LANES; i++) begin
      if (hit[i]) begin
        n_hit = n_hit + 1;
        if (!any_hit || (lkey_q[i*KEY_W +: KEY_W] < min_key))
          min_key = lkey_q[i*KEY_W +: KEY_W];
        any_hit = 1'b1;
      end
    end

    // In mode 0 a match seen this cycle already suppresses further issues.
    can_issue = (state_q == S_DISPATCH) && (next_q <= {1'b0, hi_q}) &&
                !(!mode_q && any_hit);

    // Round-robin search starting at the lane after the last one issued.
    for (int j = 1; j <= LANES; j++) begin
      for (int i = 0; i < LANES; i++) begin
        if (!sel_found && (i == (int'(last_q) + j) % LANES) &&
            lane_rdy[i] && !outst_q[i]) begin
          sel_found = 1'b1;
          sel       = IW'(i);
        end
      end
    end

    for (int i = 0; i < LANES; i++) begin
      en_c[i] = can_issue && sel_found && (sel == IW'(i));
      if (en_c[i]) lkey_d[i*KEY_W +: KEY_W] = next_q[KEY_W-1:0];
    end
    if (can_issue && sel_found) begin
      next_d = next_q + 1'b1;
      last_d = sel;
    end

    outst_d = (outst_q & ~lane_done) | en_c;

    if (any_hit) begin
      if (!kv_q || (min_key < key_q)) begin
        key_d = min_key;
        kv_d  = 1'b1;
      end
      if (!mode_q) begin
        cnt_d = CNT_W'(1);
      end else begin
        sum   = {1'b0, cnt_q} + (CNT_W+1)'(n_hit);
        cnt_d = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
      end
    end

    case (state_q)
      S_IDLE: begin
        if (en) begin
          hi_d    = key_hi;
          mode_d  = mode;
          next_d  = {1'b0, key_lo};
          key_d   = '0;
          kv_d    = 1'b0;
          cnt_d   = '0;
          state_d = (key_hi < key_lo) ? S_DRAIN : S_DISPATCH;
        end
      end
      S_DISPATCH: begin
        if ((next_d > {1'b0, hi_q}) || (!mode_q && any_hit))
          state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (outst_d == '0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      next_q  <= '0;
      hi_q    <= '0;
      mode_q  <= 1'b0;
      last_q  <= '0;
      outst_q <= '0;
      lkey_q  <= '0;
      key_q   <= '0;
      kv_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      next_q  <= next_d;
      hi_q    <= hi_d;
      mode_q  <= mode_d;
      last_q  <= last_d;
      outst_q <= outst_d;
      lkey_q  <= lkey_d;
      key_q   <= key_d;
      kv_q    <= kv_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rdy       = (state_q == S_IDLE);
  assign lane_en   = en_c;
  // The issuing slice shows its new key in the same cycle as its lane_en pulse.
  assign lane_key  = lkey_d;
  assign key       = key_q;
  assign key_valid = kv_q;
  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_crack_multi.sv
// tb/tb_crack_multi.sv - self-checking bench for crack_multi
module tb_crack_multi;
  localparam int LANES = 4;
  localparam int KW    = 24;
  localparam int CW    = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic              rdy;
  logic [KW-1:0]     key_lo, key_hi;
  logic              mode;
  logic [KW-1:0]     key;
  logic              key_valid;
  logic [CW-1:0]     match_cnt;
  logic [LANES-1:0]  lane_en;
  logic [LANES*KW-1:0] lane_key;
  logic [LANES-1:0]  lane_rdy, lane_done, lane_match;

  always #5 clk = ~clk;

  crack_multi #(.LANES(LANES), .KEY_W(KW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .rdy(rdy), .key_lo(key_lo), .key_hi(key_hi),
    .mode(mode), .key(key), .key_valid(key_valid), .match_cnt(match_cnt),
    .lane_en(lane_en), .lane_key(lane_key), .lane_rdy(lane_rdy),
    .lane_done(lane_done), .lane_match(lane_match)
  );

  int checks = 0;
  int errors = 0;

  // lane model configuration
  int            mtype;
  logic [KW-1:0] ma, mb, slow_key;
  int            slow_lat, base_lat, spread, salt;

  // monitor state, reset at each accept
  logic [KW:0]   exp_next;
  int            issue_cnt, seq_err, stop_err, busy_err, multi_err;
  bit            match_seen, run_mode;

  function automatic bit is_match(input logic [KW-1:0] k);
    case (mtype)
      0:       return (k == ma) || (k == mb);
      1:       return k[0];
      2:       return ((int'(k) ^ salt) % 5) == 0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic int lat_of(input logic [KW-1:0] k);
    if (k == slow_key) return slow_lat;
    return base_lat + ((int'(k) ^ salt) % (spread + 1));
  endfunction

  // Behavioural lanes: take a key on lane_en, stay busy for lat_of(key) cycles,
  // then pulse done with the match result. Also monitors issue ordering.
  initial begin : lanes
    bit               busy [LANES];
    bit               iss  [LANES];
    int               rem  [LANES];
    logic [KW-1:0]    lk   [LANES];
    logic [LANES-1:0] r, d, m;
    int               n;
    for (int i = 0; i < LANES; i++) begin
      busy[i] = 0; iss[i] = 0; rem[i] = 0; lk[i] = '0;
    end
    lane_rdy = '1; lane_done = '0; lane_match = '0;
    forever begin
      @(posedge clk); #1;
      r = lane_rdy; d = '0; m = '0;
      for (int i = 0; i < LANES; i++) begin
        if (iss[i]) begin
          iss[i] = 0; busy[i] = 1; rem[i] = lat_of(lk[i]); r[i] = 1'b0;
        end else if (busy[i]) begin
          rem[i]--;
          if (rem[i] <= 0) begin
            busy[i] = 0; r[i] = 1'b1; d[i] = 1'b1; m[i] = is_match(lk[i]);
          end
        end
      end
      lane_rdy = r; lane_done = d; lane_match = m;
      if (!run_mode && |(d & m)) match_seen = 1;
      @(negedge clk);
      n = 0;
      for (int i = 0; i < LANES; i++) begin
        if (lane_en[i]) begin
          n++;
          if (busy[i] || iss[i]) busy_err++;
          iss[i] = 1;
          lk[i]  = lane_key[i*KW +: KW];
          if ({1'b0, lk[i]} !== exp_next) seq_err++;
          exp_next++;
          issue_cnt++;
          if (match_seen) stop_err++;
        end
      end
      if (n > 1) multi_err++;
    end
  end

  task automatic set_cfg(input int mt, input logic [KW-1:0] a, input logic [KW-1:0] b,
                         input logic [KW-1:0] sk, input int sl, input int bl, input int sp);
    mtype = mt; ma = a; mb = b; slow_key = sk; slow_lat = sl; base_lat = bl; spread = sp;
  endtask

  task automatic start(input logic [KW-1:0] lo, input logic [KW-1:0] hi, input logic md);
    @(posedge clk); #2;
    key_lo = lo; key_hi = hi; mode = md; en = 1'b1;
    exp_next = {1'b0, lo}; issue_cnt = 0; seq_err = 0; stop_err = 0; busy_err = 0;
    multi_err = 0; match_seen = 0; run_mode = md;
    @(posedge clk); #2;
    en = 1'b0;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    @(negedge clk);
    while (!rdy && cycles < 5000) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; key_lo = '0; key_hi = '0; mode = 1'b0;
    set_cfg(3, 0, 0, 0, 1, 1, 0); salt = 0; run_mode = 1;
    repeat (2) @(negedge clk);
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy got %0b exp 1", rdy); end
    checks++; if (key !== '0) begin errors++; $display("FAIL reset_key got %h exp 0", key); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_kv got %0b exp 0", key_valid); end
    checks++; if (match_cnt !== '0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", match_cnt); end
    checks++; if (lane_en !== '0) begin errors++; $display("FAIL reset_lane_en got %b exp 0", lane_en); end
    checks++; if (lane_key !== '0) begin errors++; $display("FAIL reset_lane_key got %h exp 0", lane_key); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_first_match();
    int cyc;
    set_cfg(0, 24'h17, 24'h17, 24'hFFFFFF, 7, 7, 0);
    start(24'h10, 24'h1F, 1'b0);
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL fm_busy rdy got %0b exp 0", rdy); end
    wait_idle(cyc);
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL fm_timeout rdy got %0b exp 1", rdy); end
    checks++; if (key !== 24'h17) begin errors++; $display("FAIL fm_key got %h exp 17", key); end
    checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL fm_kv got %0b exp 1", key_valid); end
    checks++; if (match_cnt !== 16'd1) begin errors++; $display("FAIL fm_cnt got %0d exp 1", match_cnt); end
    checks++; if (stop_err !== 0) begin errors++; $display("FAIL fm_issue_after_match got %0d exp 0", stop_err); end
    checks++; if (seq_err + busy_err + multi_err !== 0) begin errors++; $display("FAIL fm_issue_order got %0d exp 0", seq_err + busy_err + multi_err); end
  endtask

  task automatic test_out_of_order();
    int cyc;
    set_cfg(0, 24'h15, 24'h12, 24'h12, 25, 7, 0);
    start(24'h10, 24'h1F, 1'b0);
    wait_idle(cyc);
    checks++; if (key !== 24'h12) begin errors++; $display("FAIL ooo_key got %h exp 12", key); end
    checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL ooo_kv got %0b exp 1", key_valid); end
    checks++; if (match_cnt !== 16'd1) begin errors++; $display("FAIL ooo_cnt got %0d exp 1", match_cnt); end
    checks++; if (stop_err !== 0) begin errors++; $display("FAIL ooo_issue_after_match got %0d exp 0", stop_err); end
  endtask

  task automatic test_exhaustive();
    int cyc;
    set_cfg(1, 0, 0, 24'hFFFFFF, 7, 7, 0);
    start(24'h000000, 24'h0000FF, 1'b1);
    wait_idle(cyc);
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL ex_timeout rdy got %0b exp 1", rdy); end
    checks++; if (match_cnt !== 16'd128) begin errors++; $display("FAIL ex_cnt got %0d exp 128", match_cnt); end
    checks++; if (key !== 24'h000001) begin errors++; $display("FAIL ex_key got %h exp 1", key); end
    checks++; if (issue_cnt !== 256) begin errors++; $display("FAIL ex_issues got %0d exp 256", issue_cnt); end
    checks++; if (seq_err + busy_err + multi_err !== 0) begin errors++; $display("FAIL ex_issue_order got %0d exp 0", seq_err + busy_err + multi_err); end
  endtask

  task automatic test_empty_range();
    int cyc;
    set_cfg(3, 0, 0, 24'hFFFFFF, 1, 3, 0);
    start(24'h20, 24'h1F, 1'b1);
    wait_idle(cyc);
    checks++; if (!(rdy === 1'b1 && cyc <= 3)) begin errors++; $display("FAIL empty_rdy got rdy=%0b after %0d cycles exp 1 within 3", rdy, cyc); end
    checks++; if (issue_cnt !== 0) begin errors++; $display("FAIL empty_issues got %0d exp 0", issue_cnt); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL empty_kv got %0b exp 0", key_valid); end
    checks++; if (match_cnt !== '0) begin errors++; $display("FAIL empty_cnt got %0d exp 0", match_cnt); end
  endtask

  task automatic test_top_of_range();
    int cyc;
    set_cfg(3, 0, 0, 24'hFFFFFF, 1, 4, 0);
    start(24'hFFFFFF, 24'hFFFFFF, 1'b0);
    wait_idle(cyc);
    checks++; if (issue_cnt !== 1) begin errors++; $display("FAIL top1_issues got %0d exp 1", issue_cnt); end
    checks++; if (key !== 24'hFFFFFF) begin errors++; $display("FAIL top1_key got %h exp ffffff", key); end
    checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL top1_kv got %0b exp 1", key_valid); end
    checks++; if (seq_err !== 0) begin errors++; $display("FAIL top1_seq got %0d exp 0", seq_err); end
    start(24'hFFFFFD, 24'hFFFFFF, 1'b1);
    wait_idle(cyc);
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL top3_timeout rdy got %0b exp 1", rdy); end
    checks++; if (issue_cnt !== 3) begin errors++; $display("FAIL top3_issues got %0d exp 3", issue_cnt); end
    checks++; if (match_cnt !== 16'd3) begin errors++; $display("FAIL top3_cnt got %0d exp 3", match_cnt); end
    checks++; if (key !== 24'hFFFFFD) begin errors++; $display("FAIL top3_key got %h exp fffffd", key); end
  endtask

  task automatic test_reset_mid_search();
    int cyc;
    int guard;
    set_cfg(3, 0, 0, 24'hFFFFFF, 30, 30, 0);
    start(24'h000000, 24'h0000FF, 1'b1);
    guard = 0;
    while (issue_cnt < 2 && guard < 100) begin @(negedge clk); guard++; end
    checks++; if (issue_cnt < 2) begin errors++; $display("FAIL mid_issue_wait got %0d issues exp >=2", issue_cnt); end
    #2 rst = 1'b1;
    #1;
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL mid_rst_rdy got %0b exp 1", rdy); end
    checks++; if (lane_en !== '0) begin errors++; $display("FAIL mid_rst_lane_en got %b exp 0", lane_en); end
    checks++; if (lane_key !== '0) begin errors++; $display("FAIL mid_rst_lane_key got %h exp 0", lane_key); end
    checks++; if (match_cnt !== '0 || key_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_result got cnt=%0d kv=%0b exp 0/0", match_cnt, key_valid); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    checks++; if (key_valid !== 1'b0 || match_cnt !== '0) begin errors++; $display("FAIL mid_stray_done got cnt=%0d kv=%0b exp 0/0", match_cnt, key_valid); end
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL mid_stray_rdy got %0b exp 1", rdy); end
    set_cfg(3, 0, 0, 24'hFFFFFF, 3, 3, 0);
    start(24'h40, 24'h47, 1'b1);
    wait_idle(cyc);
    checks++; if (match_cnt !== 16'd8) begin errors++; $display("FAIL mid_rerun_cnt got %0d exp 8", match_cnt); end
    checks++; if (key !== 24'h40) begin errors++; $display("FAIL mid_rerun_key got %h exp 40", key); end
    checks++; if (issue_cnt !== 8) begin errors++; $display("FAIL mid_rerun_issues got %0d exp 8", issue_cnt); end
  endtask

  task automatic test_random();
    int cyc, span, found, cnt, exp_cnt;
    logic [KW-1:0] lo, hi, mn;
    logic md;
    for (int it = 0; it < 10; it++) begin
      lo   = KW'($urandom_range(0, 24'hFFFFC0));
      span = $urandom_range(0, 40);
      hi   = lo + KW'(span);
      md   = 1'($urandom_range(0, 1));
      salt = $urandom_range(0, 1000);
      set_cfg(2, 0, 0, lo, $urandom_range(1, 30), $urandom_range(1, 9), $urandom_range(0, 6));
      found = 0; cnt = 0; mn = '0;
      for (int k = int'(lo); k <= int'(hi); k++) begin
        if (is_match(KW'(k))) begin
          if (found == 0) mn = KW'(k);
          found = 1;
          cnt++;
        end
      end
      exp_cnt = md ? cnt : found;
      start(lo, hi, md);
      wait_idle(cyc);
      checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL rnd%0d_timeout rdy got %0b exp 1", it, rdy); end
      checks++; if (key_valid !== 1'(found)) begin errors++; $display("FAIL rnd%0d_kv got %0b exp %0d", it, key_valid, found); end
      checks++; if (key !== mn) begin errors++; $display("FAIL rnd%0d_key got %h exp %h", it, key, mn); end
      checks++; if (match_cnt !== CW'(exp_cnt)) begin errors++; $display("FAIL rnd%0d_cnt got %0d exp %0d", it, match_cnt, exp_cnt); end
      checks++;
      if (md || found == 0) begin
        if (issue_cnt !== span + 1) begin errors++; $display("FAIL rnd%0d_issues got %0d exp %0d", it, issue_cnt, span + 1); end
      end else begin
        if (issue_cnt < int'(mn - lo) + 1 || issue_cnt > span + 1) begin
          errors++; $display("FAIL rnd%0d_issues got %0d exp %0d..%0d", it, issue_cnt, int'(mn - lo) + 1, span + 1);
        end
      end
      checks++; if (seq_err + busy_err + multi_err + stop_err !== 0) begin errors++; $display("FAIL rnd%0d_issue_rules got %0d exp 0", it, seq_err + busy_err + multi_err + stop_err); end
    end
  endtask

  initial begin
    test_reset();
    test_first_match();
    test_out_of_order();
    test_exhaustive();
    test_empty_range();
    test_top_of_range();
    test_reset_mid_search();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
